// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch/decode sequencer for a 12-bit instruction set.
// Fetches from program memory, resolves control flow locally and issues ALU ops to the datapath.
module fetch_sequencer #(
  parameter logic [8:0] PC_RESET    = 9'h000,
  parameter int         ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic [8:0]  mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [11:0] mem_data,
  output logic [11:0] instr,
  output logic        issue,
  input  logic        dp_done,
  input  logic        dp_zero,
  output logic [8:0]  pc,
  output logic        halted,
  output logic        fault
);

  // state  | meaning
  // IDLE   | waiting for run
  // FETCH  | mem_req high, waiting for mem_ack (bounded by ACK_TIMEOUT)
  // DECODE | instr valid; resolve control flow or issue an ALU op
  // EXEC   | datapath busy, waiting for dp_done
  // HALT   | HALT executed; terminal until rst
  // FAULT  | fetch timeout or illegal opcode; terminal until rst
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam int            CW    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(ACK_TIMEOUT - 1);

  // opcode sits in the most significant nibble (bit 0 of the ISA numbering is the MSB)
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_ADC  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t        state, state_nxt;
  state_t        fetch_or_idle;
  logic [8:0]    pc_nxt;
  logic [8:0]    pc_inc;
  logic [8:0]    target;
  logic [11:0]   instr_nxt;
  logic [3:0]    opcode;
  logic [CW-1:0] tmo, tmo_nxt;

  assign opcode        = instr[11:8];
  assign target        = {1'b0, instr[7:0]};
  assign pc_inc        = pc + 9'd1;
  assign fetch_or_idle = run ? S_FETCH : S_IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      pc    <= PC_RESET;
      instr <= 12'h000;
      tmo   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      instr <= instr_nxt;
      tmo   <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    tmo_nxt   = tmo;
    issue     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (run) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        // an ack arriving on the limit cycle still wins over the timeout
        if (mem_ack) begin
          instr_nxt = mem_data;
          tmo_nxt   = '0;
          state_nxt = S_DECODE;
        end else if (tmo == LIMIT) begin
          tmo_nxt   = '0;
          state_nxt = S_FAULT;
        end else begin
          tmo_nxt   = tmo + CW'(1);
        end
      end
      S_DECODE: begin
        unique case (opcode)
          OP_NOP: begin
            pc_nxt    = pc_inc;
            state_nxt = fetch_or_idle;
          end
          OP_ADD, OP_ADC, OP_MOV, OP_LDI: begin
            issue     = 1'b1;
            state_nxt = S_EXEC;
          end
          OP_JZ: begin
            pc_nxt    = dp_zero ? target : pc_inc;
            state_nxt = fetch_or_idle;
          end
          OP_JMP: begin
            pc_nxt    = target;
            state_nxt = fetch_or_idle;
          end
          OP_HALT: state_nxt = S_HALT;
          default: state_nxt = S_FAULT;
        endcase
      end
      S_EXEC: begin
        if (dp_done) begin
          pc_nxt    = pc_inc;
          state_nxt = fetch_or_idle;
        end
      end
      S_HALT:  state_nxt = S_HALT;
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign mem_addr = pc;
  assign mem_req  = (state == S_FETCH);
  assign halted   = (state == S_HALT);
  assign fault    = (state == S_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: vector table, hand-written corner sequences and a randomized run
// checked against an instruction-level interpreter of the program memory.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, run, mem_ack, dp_done, dp_zero;
  logic [11:0] mem_data;
  logic [8:0]  mem_addr, pc;
  logic        mem_req, issue, halted, fault;
  logic [11:0] instr;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .run(run),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr(instr), .issue(issue), .dp_done(dp_done), .dp_zero(dp_zero),
    .pc(pc), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- interpreter-level model ----------------
  logic [11:0] prog [512];
  logic [8:0]  model_pc;
  logic        exp_issue;
  int          done_cnt, wait_cnt, n_acks, n_alu, n_issue, cyc;
  int          ack_cyc [$];
  logic [8:0]  ack_addr [$];

  task automatic model_reset();
    model_pc  = 9'h000;
    exp_issue = 1'b0;
    done_cnt  = 0;
    wait_cnt  = 0;
    n_acks    = 0;
    n_alu     = 0;
    n_issue   = 0;
    cyc       = 0;
    ack_cyc.delete();
    ack_addr.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; mem_data = 12'h000; dp_done = 1'b0; dp_zero = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One cycle of memory/datapath responder plus model bookkeeping.
  task automatic step(input bit rand_delay, input bit rand_run);
    logic [11:0] w;
    @(negedge clk);
    cyc++;
    chk("issue_pulse", 32'(issue), 32'(exp_issue));
    exp_issue = 1'b0;
    if (issue) begin
      n_issue++;
      done_cnt = rand_delay ? $urandom_range(1, 3) : 1;
      dp_done  = rand_delay ? 1'($urandom % 2) : 1'b0;  // dp_done during DECODE must be ignored
    end else if (done_cnt > 0) begin
      done_cnt--;
      dp_done = (done_cnt == 0);
    end else begin
      dp_done = 1'b0;
    end
    mem_ack = 1'b0;
    if (mem_req) begin
      if (wait_cnt == 0) begin
        chk("fetch_addr", 32'(mem_addr), 32'(model_pc));
        w        = prog[mem_addr];
        mem_ack  = 1'b1;
        mem_data = w;
        dp_zero  = 1'($urandom % 2);
        n_acks++;
        ack_cyc.push_back(cyc);
        ack_addr.push_back(mem_addr);
        case (w[11:8])
          4'h1, 4'h2, 4'h3, 4'h4: begin exp_issue = 1'b1; n_alu++; model_pc = model_pc + 9'd1; end
          4'hD:    model_pc = dp_zero ? {1'b0, w[7:0]} : model_pc + 9'd1;
          4'hE:    model_pc = {1'b0, w[7:0]};
          default: model_pc = model_pc + 9'd1;
        endcase
        wait_cnt = rand_delay ? $urandom_range(0, 5) : 0;
      end else begin
        wait_cnt--;
      end
    end
    if (rand_run) run = ($urandom % 5) != 0;
  endtask

  task automatic wait_req(input string name);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mem_req) got = 1;
    end
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s: got no mem_req expected mem_req within 20 cycles", name);
    end
  endtask

  // ---------------- single-instruction vector table ----------------
  typedef struct {
    logic [11:0] word;
    logic        zero;
    logic [8:0]  exp_addr;
    int          exp_issue;
    logic        exp_halt;
    logic        exp_fault;
  } vec_t;

  vec_t tbl [13];

  task automatic run_one(input vec_t v, output logic [8:0] addr, output int nis,
                         output logic hlt, output logic flt);
    int cnt = 0;
    do_reset();
    run = 1'b1;
    wait_req("vec_first_fetch");
    mem_ack = 1'b1; mem_data = v.word; dp_zero = v.zero;
    @(negedge clk);
    mem_ack = 1'b0;
    nis = 0;
    for (int i = 0; i < 12; i++) begin
      if (mem_req || halted || fault) break;
      if (issue) begin
        nis++;
        cnt = 2;
        dp_done = 1'b0;
      end else if (cnt > 0) begin
        cnt--;
        dp_done = (cnt == 0);
      end else begin
        dp_done = 1'b0;
      end
      @(negedge clk);
    end
    dp_done = 1'b0;
    addr = mem_addr; hlt = halted; flt = fault;
  endtask

  initial begin
    logic [8:0] a;
    int         nis;
    logic       h, f;
    bit         seen_1ff, done;

    tbl[0]  = '{12'h000, 1'b0, 9'h001, 1, 1'b0, 1'b0};
    tbl[0].exp_issue = 0;
    tbl[1]  = '{12'h1AB, 1'b0, 9'h001, 1, 1'b0, 1'b0};
    tbl[2]  = '{12'h2FF, 1'b1, 9'h001, 1, 1'b0, 1'b0};
    tbl[3]  = '{12'h312, 1'b0, 9'h001, 1, 1'b0, 1'b0};
    tbl[4]  = '{12'h4C3, 1'b0, 9'h001, 1, 1'b0, 1'b0};
    tbl[5]  = '{12'hE5A, 1'b0, 9'h05A, 0, 1'b0, 1'b0};
    tbl[6]  = '{12'hD10, 1'b0, 9'h001, 0, 1'b0, 1'b0};
    tbl[7]  = '{12'hD10, 1'b1, 9'h010, 0, 1'b0, 1'b0};
    tbl[8]  = '{12'h7AA, 1'b0, 9'h000, 0, 1'b0, 1'b1};
    tbl[9]  = '{12'h500, 1'b0, 9'h000, 0, 1'b0, 1'b1};
    tbl[10] = '{12'hC34, 1'b1, 9'h000, 0, 1'b0, 1'b1};
    tbl[11] = '{12'hF00, 1'b0, 9'h000, 0, 1'b1, 1'b0};
    tbl[12] = '{12'hEFF, 1'b1, 9'h0FF, 0, 1'b0, 1'b0};

    // reset state
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_issue", 32'(issue), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_instr", 32'(instr), 0);
    repeat (3) @(negedge clk);
    chk("idle_no_req", 32'(mem_req), 0);

    for (int i = 0; i < 13; i++) begin
      run_one(tbl[i], a, nis, h, f);
      chk($sformatf("vec%0d_addr", i), 32'(a), 32'(tbl[i].exp_addr));
      chk($sformatf("vec%0d_issues", i), 32'(nis), 32'(tbl[i].exp_issue));
      chk($sformatf("vec%0d_halted", i), 32'(h), 32'(tbl[i].exp_halt));
      chk($sformatf("vec%0d_fault", i), 32'(f), 32'(tbl[i].exp_fault));
    end

    // NOP stream with same-cycle ack: one fetch every 2 cycles
    for (int i = 0; i < 512; i++) prog[i] = 12'h000;
    do_reset(); model_reset(); run = 1'b1;
    for (int i = 0; i < 12; i++) step(0, 0);
    chk("nop_acks", 32'(n_acks >= 4), 1);
    if (n_acks >= 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("nop_addr%0d", i), 32'(ack_addr[i]), 32'(i));
      for (int i = 1; i < 4; i++) chk($sformatf("nop_gap%0d", i), 32'(ack_cyc[i] - ack_cyc[i-1]), 2);
    end
    chk("nop_no_issue", 32'(n_issue), 0);

    // pc wrap: JMP to 0FF then NOPs up through 1FF
    prog[0] = 12'hEFF;
    do_reset(); model_reset(); run = 1'b1;
    seen_1ff = 0; done = 0;
    for (int i = 0; i < 1200 && !done; i++) begin
      step(0, 0);
      if (n_acks == 2 && mem_ack) chk("jmp_ff_addr", 32'(mem_addr), 32'h0FF);
      if (mem_ack && seen_1ff) begin
        chk("wrap_addr", 32'(mem_addr), 0);
        done = 1;
      end
      if (mem_ack && mem_addr == 9'h1FF) seen_1ff = 1;
    end
    if (!done) chk("wrap_reached", 0, 1);
    mem_ack = 1'b0;

    // fetch timeout: 15 unacked FETCH cycles -> FAULT on the 16th
    do_reset(); run = 1'b1;
    wait_req("tmo_fetch");
    for (int k = 2; k <= 15; k++) @(negedge clk);
    chk("tmo_c15_fault", 32'(fault), 0);
    chk("tmo_c15_req", 32'(mem_req), 1);
    @(negedge clk);
    chk("tmo_c16_fault", 32'(fault), 1);
    chk("tmo_c16_req", 32'(mem_req), 0);
    for (int k = 0; k < 5; k++) begin
      run = ~run;
      @(negedge clk);
    end
    chk("tmo_fault_sticky", 32'(fault), 1);

    // ack on the 15th cycle still wins
    do_reset(); run = 1'b1;
    wait_req("tmo15_fetch");
    for (int k = 2; k <= 15; k++) @(negedge clk);
    mem_ack = 1'b1; mem_data = 12'h000;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("tmo15_no_fault", 32'(fault), 0);
    @(negedge clk);
    chk("tmo15_refetch", 32'(mem_req), 1);
    chk("tmo15_addr", 32'(mem_addr), 1);

    // HALT is terminal, then reset clears it
    do_reset(); run = 1'b1;
    wait_req("halt_fetch");
    mem_ack = 1'b1; mem_data = 12'hF3C;
    @(negedge clk);
    mem_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("halt_sticky", 32'(halted), 1);
    chk("halt_no_req", 32'(mem_req), 0);
    chk("halt_pc", 32'(pc), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("halt_rst_flag", 32'(halted), 0);
    chk("halt_rst_fault", 32'(fault), 0);

    // run dropped during EXEC: finish, park in IDLE at pc+1, resume there
    do_reset(); run = 1'b1;
    wait_req("rd_fetch");
    mem_ack = 1'b1; mem_data = 12'h1AB;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("rd_issue", 32'(issue), 1);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    dp_done = 1'b1;
    @(negedge clk);
    dp_done = 1'b0;
    chk("rd_pc", 32'(pc), 1);
    repeat (3) @(negedge clk);
    chk("rd_idle", 32'(mem_req), 0);
    run = 1'b1;
    wait_req("rd_resume");
    chk("rd_resume_addr", 32'(mem_addr), 1);

    // reset mid-EXEC aborts
    do_reset(); run = 1'b1;
    wait_req("rx_fetch");
    mem_ack = 1'b1; mem_data = 12'h2AB;
    @(negedge clk);
    mem_ack = 1'b0; run = 1'b0;
    @(negedge clk);
    rst = 1'b1; dp_done = 1'b1;
    @(negedge clk);
    rst = 1'b0; dp_done = 1'b0;
    chk("rx_pc", 32'(pc), 0);
    chk("rx_instr", 32'(instr), 0);
    chk("rx_issue", 32'(issue), 0);

    // reset mid-FETCH aborts, ack ignored
    run = 1'b1;
    wait_req("rf_fetch");
    rst = 1'b1; mem_ack = 1'b1; mem_data = 12'h3AB;
    @(negedge clk);
    rst = 1'b0; mem_ack = 1'b0; run = 1'b0;
    chk("rf_instr", 32'(instr), 0);
    chk("rf_req", 32'(mem_req), 0);
    @(negedge clk);
    chk("rf_issue", 32'(issue), 0);

    // randomized program with random ack/done latency and run toggling
    for (int i = 0; i < 512; i++) begin
      case ($urandom % 7)
        0: prog[i] = {4'h0, 8'($urandom)};
        1: prog[i] = {4'h1, 8'($urandom)};
        2: prog[i] = {4'h2, 8'($urandom)};
        3: prog[i] = {4'h3, 8'($urandom)};
        4: prog[i] = {4'h4, 8'($urandom)};
        5: prog[i] = {4'hD, 8'($urandom)};
        default: prog[i] = {4'hE, 8'($urandom)};
      endcase
    end
    do_reset(); model_reset(); run = 1'b1;
    for (int i = 0; i < 3000; i++) step(1, 1);
    chk("rand_issue_count", 32'(n_issue), 32'(n_alu));
    chk("rand_progress", 32'(n_acks > 150), 1);
    chk("rand_no_fault", 32'(fault), 0);
    chk("rand_no_halt", 32'(halted), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
